// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage and its MEM/WB register.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_GNT  = 2'd1,
    WAIT_RESP = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_TIMEOUT = 255;
  localparam int          CNT_W           = 8;
  localparam logic [1:0]  WORD_ALIGN_MASK = 2'b11;

  function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
    return (addr_lsb & WORD_ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/mem_wb.sv
// MEM/WB pipeline register; a bubble clears the write-back controls while the
// data fields hold unless explicitly loaded.
module mem_wb (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_en,
  input  logic        bubble,
  input  logic        reg_write,
  input  logic        mem_to_reg,
  input  logic [4:0]  reg_id_w,
  input  logic [31:0] alu_result,
  input  logic        data_we,
  input  logic [31:0] mem_data,
  output logic        reg_write_o,
  output logic        mem_to_reg_o,
  output logic [4:0]  reg_id_wo,
  output logic [31:0] alu_result_o,
  output logic [31:0] mem_data_o
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_write_o  <= 1'b0;
      mem_to_reg_o <= 1'b0;
      reg_id_wo    <= '0;
      alu_result_o <= '0;
      mem_data_o   <= '0;
    end else begin
      reg_write_o  <= reg_write  & ~bubble;
      mem_to_reg_o <= mem_to_reg & ~bubble;
      if (load_en) begin
        reg_id_wo    <= reg_id_w;
        alu_result_o <= alu_result;
      end
      if (data_we) mem_data_o <= mem_data;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: branch resolution, word load/store over a req/gnt/rvalid bus with
// pipeline stall and timeout abort, feeding the MEM/WB register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
  parameter int          ADDR_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [31:0] result,
  input  logic signed [31:0] read_data2,
  input  logic               zero,
  input  logic               branch,
  input  logic [31:0]        branch_pc,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic               mem_to_reg,
  input  logic               reg_write,
  input  logic [4:0]         reg_id_w,
  output logic               pc_src_o,
  output logic [31:0]        branch_target_o,
  output logic               stall_o,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [ADDR_W-1:0]  dmem_addr,
  output logic [31:0]        dmem_wdata,
  input  logic               dmem_gnt,
  input  logic               dmem_rvalid,
  input  logic [31:0]        dmem_rdata,
  output logic               reg_write_o,
  output logic               mem_to_reg_o,
  output logic [4:0]         reg_id_wo,
  output logic [31:0]        alu_result_o,
  output logic [31:0]        mem_data_o,
  output logic               misalign_o,
  output logic               bus_err_o
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_op, pending, misalign;
  logic             req, done, abort, load_done;

  assign pc_src_o        = branch & zero;
  assign branch_target_o = branch_pc;

  assign mem_op   = mem_read | mem_write;
  assign pending  = mem_op &  is_word_aligned(result[1:0]);
  assign misalign = mem_op & ~is_word_aligned(result[1:0]);

  // NOTE: every signal driven here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req       = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    load_done = 1'b0;
    unique case (state_q)
      IDLE, WAIT_GNT: begin
        if (!pending) begin
          state_d = IDLE;
        end else begin
          req = 1'b1;
          if (dmem_gnt) begin
            // A grant beats a coincident timeout.
            if (mem_write) begin
              done    = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = WAIT_RESP;
            end
          end else if (state_q == WAIT_GNT && cnt_q == TIMEOUT_CNT) begin
            abort   = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WAIT_GNT;
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
      WAIT_RESP: begin
        if (dmem_rvalid) begin
          done      = 1'b1;
          load_done = 1'b1;
          state_d   = IDLE;
        end else if (cnt_q == TIMEOUT_CNT) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      misalign_o <= misalign;
      bus_err_o  <= abort;
    end
  end

  // Gated by rst so the bus and pipeline see nothing while reset is held.
  assign stall_o    = rst & pending & ~done & ~abort;
  assign dmem_req   = rst & req;
  assign dmem_we    = dmem_req & mem_write;
  assign dmem_addr  = dmem_req ? result[ADDR_W-1:0] : '0;
  assign dmem_wdata = dmem_req ? read_data2 : '0;

  mem_wb u_mem_wb (
    .clk          (clk),
    .rst          (rst),
    .load_en      (~stall_o),
    .bubble       (stall_o | misalign | abort),
    .reg_write    (reg_write),
    .mem_to_reg   (mem_to_reg),
    .reg_id_w     (reg_id_w),
    .alu_result   (result),
    .data_we      (load_done),
    .mem_data     (dmem_rdata),
    .reg_write_o  (reg_write_o),
    .mem_to_reg_o (mem_to_reg_o),
    .reg_id_wo    (reg_id_wo),
    .alu_result_o (alu_result_o),
    .mem_data_o   (mem_data_o)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with TIMEOUT=4 and hand-computed expectations.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [31:0] result, read_data2;
  logic               zero, branch;
  logic [31:0]        branch_pc;
  logic               mem_read, mem_write, mem_to_reg, reg_write;
  logic [4:0]         reg_id_w;
  logic               pc_src_o, stall_o;
  logic [31:0]        branch_target_o;
  logic               dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0]        dmem_addr, dmem_wdata, dmem_rdata;
  logic               reg_write_o, mem_to_reg_o, misalign_o, bus_err_o;
  logic [4:0]         reg_id_wo;
  logic [31:0]        alu_result_o, mem_data_o;

  int vectors     = 0;
  int miscompares = 0;
  int writes_seen = 0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(4), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .result(result), .read_data2(read_data2),
    .zero(zero), .branch(branch), .branch_pc(branch_pc),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .reg_id_w(reg_id_w),
    .pc_src_o(pc_src_o), .branch_target_o(branch_target_o), .stall_o(stall_o),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .reg_write_o(reg_write_o),
    .mem_to_reg_o(mem_to_reg_o), .reg_id_wo(reg_id_wo),
    .alu_result_o(alu_result_o), .mem_data_o(mem_data_o),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  always @(posedge clk) if (dmem_req && dmem_gnt && dmem_we) writes_seen++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    result = '0; read_data2 = '0; zero = 0; branch = 0; branch_pc = '0;
    mem_read = 0; mem_write = 0; mem_to_reg = 0; reg_write = 0; reg_id_w = '0;
    dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".reg_write_o"},  32'(reg_write_o),  32'd0);
    check({tag, ".mem_to_reg_o"}, 32'(mem_to_reg_o), 32'd0);
    check({tag, ".reg_id_wo"},    32'(reg_id_wo),    32'd0);
    check({tag, ".alu_result_o"}, alu_result_o,      32'd0);
    check({tag, ".mem_data_o"},   mem_data_o,        32'd0);
    check({tag, ".misalign_o"},   32'(misalign_o),   32'd0);
    check({tag, ".bus_err_o"},    32'(bus_err_o),    32'd0);
    check({tag, ".dmem_req"},     32'(dmem_req),     32'd0);
    check({tag, ".stall_o"},      32'(stall_o),      32'd0);
    check({tag, ".state"},        32'(dut.state_q),  32'(IDLE));
  endtask

  initial begin
    idle_inputs();
    rst = 0;
    tick(); tick();
    check_reset_outputs("reset");
    rst = 1;
    tick();

    // ALU op plus branch resolution
    result = 32'h1234; reg_write = 1; reg_id_w = 5;
    branch = 1; zero = 1; branch_pc = 32'h100;
    #1;
    check("alu.stall", 32'(stall_o), 32'd0);
    check("alu.req", 32'(dmem_req), 32'd0);
    check("br.pc_src", 32'(pc_src_o), 32'd1);
    check("br.target", branch_target_o, 32'h100);
    zero = 0;
    #1;
    check("br.not_taken", 32'(pc_src_o), 32'd0);
    tick();
    check("alu.result_o", alu_result_o, 32'h1234);
    check("alu.reg_id_wo", 32'(reg_id_wo), 32'd5);
    check("alu.reg_write_o", 32'(reg_write_o), 32'd1);
    check("alu.mem_to_reg_o", 32'(mem_to_reg_o), 32'd0);
    idle_inputs();

    // Store, grant withheld for 3 cycles
    result = 32'h40; read_data2 = 32'hDEADBEEF; mem_write = 1; reg_id_w = 9;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("st.stall", 32'(stall_o), 32'd1);
      check("st.req", 32'(dmem_req), 32'd1);
      check("st.we", 32'(dmem_we), 32'd1);
      check("st.addr", dmem_addr, 32'h40);
      check("st.wdata", dmem_wdata, 32'hDEADBEEF);
      tick();
      check("st.bubble", 32'(reg_write_o), 32'd0);
    end
    dmem_gnt = 1;
    #1;
    check("st.gnt_stall", 32'(stall_o), 32'd0);
    check("st.gnt_req", 32'(dmem_req), 32'd1);
    tick();
    idle_inputs();
    tick();
    check("st.writes", 32'(writes_seen), 32'd1);
    check("st.state", 32'(dut.state_q), 32'(IDLE));

    // Load, immediate grant, rvalid two cycles later
    result = 32'h80; mem_read = 1; mem_to_reg = 1; reg_write = 1; reg_id_w = 7;
    dmem_gnt = 1;
    #1;
    check("ld.c0_req", 32'(dmem_req), 32'd1);
    check("ld.c0_we", 32'(dmem_we), 32'd0);
    check("ld.c0_addr", dmem_addr, 32'h80);
    check("ld.c0_stall", 32'(stall_o), 32'd1);
    tick();
    dmem_gnt = 0;
    #1;
    check("ld.c1_req", 32'(dmem_req), 32'd0);
    check("ld.c1_stall", 32'(stall_o), 32'd1);
    check("ld.c1_state", 32'(dut.state_q), 32'(WAIT_RESP));
    tick();
    dmem_rvalid = 1; dmem_rdata = 32'hCAFEF00D;
    #1;
    check("ld.c2_stall", 32'(stall_o), 32'd0);
    tick();
    idle_inputs();
    check("ld.mem_data_o", mem_data_o, 32'hCAFEF00D);
    check("ld.mem_to_reg_o", 32'(mem_to_reg_o), 32'd1);
    check("ld.reg_write_o", 32'(reg_write_o), 32'd1);
    check("ld.reg_id_wo", 32'(reg_id_wo), 32'd7);
    check("ld.state", 32'(dut.state_q), 32'(IDLE));

    // Misaligned load
    result = 32'h82; mem_read = 1; mem_to_reg = 1; reg_write = 1; reg_id_w = 3;
    #1;
    check("mis.req", 32'(dmem_req), 32'd0);
    check("mis.stall", 32'(stall_o), 32'd0);
    tick();
    idle_inputs();
    check("mis.pulse", 32'(misalign_o), 32'd1);
    check("mis.bubble", 32'(reg_write_o), 32'd0);
    tick();
    check("mis.pulse_end", 32'(misalign_o), 32'd0);

    // Load never granted: IDLE cycle + 4 counted waits, abort on the next
    result = 32'h100; mem_read = 1; mem_to_reg = 1; reg_write = 1; reg_id_w = 4;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("to.stall", 32'(stall_o), 32'd1);
      tick();
    end
    #1;
    check("to.expire_stall", 32'(stall_o), 32'd0);
    tick();
    idle_inputs();
    check("to.bus_err", 32'(bus_err_o), 32'd1);
    check("to.bubble", 32'(reg_write_o), 32'd0);
    check("to.state", 32'(dut.state_q), 32'(IDLE));
    tick();
    check("to.bus_err_end", 32'(bus_err_o), 32'd0);

    // Store whose grant coincides with timeout expiry: grant wins
    result = 32'h44; read_data2 = 32'h11223344; mem_write = 1;
    for (int i = 0; i < 5; i++) tick();
    dmem_gnt = 1;
    #1;
    check("tg.stall", 32'(stall_o), 32'd0);
    tick();
    idle_inputs();
    check("tg.no_bus_err", 32'(bus_err_o), 32'd0);
    check("tg.writes", 32'(writes_seen), 32'd2);

    // Reset in WAIT_RESP, then a stray rvalid
    result = 32'h200; mem_read = 1; mem_to_reg = 1; reg_write = 1; reg_id_w = 2;
    dmem_gnt = 1;
    tick();
    dmem_gnt = 0;
    #1;
    check("rs.pre_state", 32'(dut.state_q), 32'(WAIT_RESP));
    rst = 0;
    #1;
    check_reset_outputs("rs.held");
    idle_inputs();
    tick();
    rst = 1;
    dmem_rvalid = 1; dmem_rdata = 32'h55AA55AA;
    tick();
    dmem_rvalid = 0;
    check("rs.mem_data_o", mem_data_o, 32'd0);
    check("rs.reg_write_o", 32'(reg_write_o), 32'd0);
    check("rs.state", 32'(dut.state_q), 32'(IDLE));
    check("rs.stall", 32'(stall_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Pipeline MEM stage with its MEM/WB register. It consumes the EX/MEM register outputs and resolves branches. It performs word loads and stores on a data-memory bus that uses a request/grant/response handshake, and stalls the upstream pipeline while an access is outstanding. The registered results go to the write-back stage.

## Interface
- `TIMEOUT`, default 255: maximum cycles spent waiting for a grant or a response before the access is aborted.
- `ADDR_W`, default 32: data-bus address width.
- `clk` input 1: clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-low reset (`rst`=0 resets).
- `result` input 32 signed: ALU result; the load/store address.
- `read_data2` input 32 signed: store data.
- `zero`, `branch` input 1 each: branch taken when both are 1.
- `branch_pc` input 32: branch target.
- `mem_read`, `mem_write`, `mem_to_reg`, `reg_write` input 1 each: control bits.
- `reg_id_w` input 5: destination register.
- `pc_src_o` output 1: combinational, `branch & zero`.
- `branch_target_o` output 32: combinational, equal to `branch_pc`.
- `stall_o` output 1: combinational; holds PC, IF/ID, ID/EX and EX/MEM.
- `dmem_req` output 1, `dmem_we` output 1, `dmem_addr` output ADDR_W, `dmem_wdata` output 32: request channel.
- `dmem_gnt` input 1: request accepted.
- `dmem_rvalid` input 1, `dmem_rdata` input 32: read response.
- `reg_write_o`, `mem_to_reg_o` output 1 each; `reg_id_wo` output 5; `alu_result_o` output 32; `mem_data_o` output 32: MEM/WB register.
- `misalign_o`, `bus_err_o` output 1 each: registered one-cycle error pulses.

## Operation
- An access is pending when `(mem_read | mem_write) & result[1:0]==0`.
- Misaligned access (`result[1:0]!=0` with `mem_read` or `mem_write` set):
  - no request is issued and there is no stall;
  - `misalign_o` pulses and the MEM/WB slot becomes a bubble (`reg_write_o`=0).
- States:
  - IDLE: no access outstanding.
  - WAIT_GNT: request issued, grant not yet seen.
  - WAIT_RESP: load granted, response not yet seen.
- In IDLE and WAIT_GNT with an access pending:
  - `dmem_req`=1; `dmem_addr`=`result[ADDR_W-1:0]`, `dmem_we`=`mem_write`, `dmem_wdata`=`read_data2`.
  - These hold stable until `dmem_gnt`.
- Request outcomes:
  - Grant on a store: access done in the same cycle.
  - Grant on a load: go to WAIT_RESP, with `dmem_req` low.
  - No grant: WAIT_GNT.
- In WAIT_RESP, `dmem_rvalid`=1 marks the load done, captures `dmem_rdata` into `mem_data_o`, and returns to IDLE.
- `stall_o` = access pending and not done this cycle.
- MEM/WB register:
  - loads only when `stall_o`=0;
  - while stalled it loads a bubble (`reg_write_o`=0, `mem_to_reg_o`=0; other fields hold).
- Timeout counter:
  - 8-bit wait counter, cleared on every state entry, incremented in WAIT_GNT and WAIT_RESP.
  - When it reaches `TIMEOUT`: abort to IDLE, pulse `bus_err_o`, write a bubble to MEM/WB, drop `stall_o` that cycle.
- `dmem_rvalid` in IDLE or WAIT_GNT is ignored.
- Branch (`pc_src_o`) is independent of the FSM. Branches never access memory.

## Timing
- Reset values (all outputs 0, with `rst` low):
  - FSM in IDLE and counter at 0;
  - `reg_write_o`, `mem_to_reg_o`, `reg_id_wo`, `alu_result_o`, `mem_data_o`, `misalign_o`, `bus_err_o` all 0.
- Reset mid-access:
  - immediate return to IDLE with `dmem_req` deasserted;
  - a later stale `dmem_rvalid` is ignored.
- Latency:
  - Non-memory instruction: 1 cycle to MEM/WB.
  - Store granted in the first cycle: 1 cycle, no stall.
  - Load with grant at cycle 0 and rvalid at cycle k: stall for k cycles, MEM/WB valid at edge k+1.
- Simultaneous `dmem_gnt` and timeout expiry: the grant wins.
- Simultaneous `dmem_rvalid` and timeout expiry: `dmem_rvalid` wins.

## Structure
- Package `mem_stage_pkg`:
  - state enum {IDLE, WAIT_GNT, WAIT_RESP};
  - default timeout constant;
  - `WORD_ALIGN_MASK` = 2'b11.
- Sub-module `mem_wb`: the MEM/WB register with a bubble-insert input. The FSM, handshake and timeout stay in `mem_stage`.

## Test plan
- ALU instruction, `result`=0x1234, `reg_write`=1, `reg_id_w`=5 → next edge `alu_result_o`=0x1234, `reg_id_wo`=5, `reg_write_o`=1; `stall_o` never asserts.
- Store to 0x40, data 0xDEADBEEF, grant held low 3 cycles:
  - required: `stall_o`=1 for 3 cycles and the request stays stable;
  - then grant → exactly one write seen, `stall_o`=0.
- Load from 0x80, grant immediately, rvalid after 2 cycles with 0xCAFEF00D → stall 2 cycles, then `mem_data_o`=0xCAFEF00D, `mem_to_reg_o`=1, `reg_write_o`=1.
- Load from 0x82 → `misalign_o` pulses, `dmem_req` stays 0, `reg_write_o`=0.
- `TIMEOUT`=4, load never granted → `bus_err_o` pulses after 4 wait cycles, FSM back in IDLE, bubble written.
- `rst` low during WAIT_RESP, then a stray rvalid after release → all outputs 0, FSM IDLE, rvalid ignored.
